// File: rtl/lsu_pkg.sv
// lsu_pkg: FSM state encoding and byte-lane widths shared by the load/store unit.
package lsu_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RMW_WR = 2'd2,
        RESP   = 2'd3
    } state_t;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align: load extraction/zero-extension/rotation, byte-store merge, eff_addr alignment.
// LSU_ROTATE_EN enables ARM-style rotated word loads and word-aligned word accesses.
module lsu_data_align import lsu_pkg::*; (
    input  logic [WORD_W-1:0]        req_addr,
    input  logic                     req_byte,
    input  logic                     byte_sel,
    input  logic [1:0]               shift,
    input  logic [WORD_W-1:0]        read_data,
    input  logic [WORD_W-BYTE_W-1:0] hold,
    input  logic [BYTE_W-1:0]        wbyte,
    output logic [WORD_W-1:0]        eff_addr,
    output logic [WORD_W-1:0]        load_data,
    output logic [WORD_W-1:0]        merge_data
);
`ifdef LSU_ROTATE_EN
    localparam bit ROTATE = 1'b1;
`else
    localparam bit ROTATE = 1'b0;
`endif
    logic [5:0]        amt;
    logic [WORD_W-1:0] rotated;
    assign amt        = {1'b0, (ROTATE ? shift : 2'd0), 3'b000};
    // a zero amount shifts the left term out entirely, leaving the word untouched
    assign rotated    = (read_data >> amt) | (read_data << (6'd32 - amt));
    assign eff_addr   = (ROTATE && !req_byte) ? {req_addr[WORD_W-1:2], 2'b00} : req_addr;
    assign load_data  = byte_sel ? {{(WORD_W-BYTE_W){1'b0}}, read_data[BYTE_W-1:0]} : rotated;
    assign merge_data = {hold, wbyte};
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator; byte stores done as read-modify-write.
// Optional LSU_ROTATE_EN (see lsu_data_align) aligns word accesses and rotates word loads.
module load_store_unit import lsu_pkg::*; #(
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              mem_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [WORD_W-1:0] mem_address,
    output logic              mem_write_en,
    output logic [WORD_W-1:0] mem_write_data,
    input  logic [WORD_W-1:0] mem_read_data
);
    localparam logic [WORD_W-1:0] LIMIT = WORD_W'(MEM_BYTES - 3);
    state_t                   state, state_nx;
    logic                     wr, byt, fault, word_wr;
    logic [1:0]               shift;
    logic [WORD_W-1:0]        wdata, eff_addr, load_data, merge_data;
    logic [WORD_W-BYTE_W-1:0] hold;
    lsu_data_align u_align (
        .req_addr   (req_addr),
        .req_byte   (req_byte),
        .byte_sel   (byt),
        .shift      (shift),
        .read_data  (mem_read_data),
        .hold       (hold),
        .wbyte      (wdata[BYTE_W-1:0]),
        .eff_addr   (eff_addr),
        .load_data  (load_data),
        .merge_data (merge_data)
    );
    always_ff @(posedge clk) begin
        if (mem_reset) state <= IDLE;
        else           state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE   ? (req_valid ? ACCESS : IDLE) :
                   state == ACCESS ? ((wr && byt && !fault) ? RMW_WR : RESP) :
                   state == RMW_WR ? RESP : IDLE;
    end
    assign req_ready      = state == IDLE;
    assign resp_valid     = state == RESP;
    assign resp_fault     = fault;
    assign word_wr        = state == ACCESS && wr && !byt && !fault;
    // reset must never let a half-finished RMW reach the memory
    assign mem_write_en   = !mem_reset && (word_wr || state == RMW_WR);
    assign mem_write_data = state == RMW_WR ? merge_data : word_wr ? wdata : '0;
    always_ff @(posedge clk) begin
        if (mem_reset) begin
            wr          <= 1'b0;
            byt         <= 1'b0;
            fault       <= 1'b0;
            shift       <= 2'd0;
            wdata       <= '0;
            hold        <= '0;
            resp_rdata  <= '0;
            mem_address <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                wr          <= req_write;
                byt         <= req_byte;
                shift       <= req_addr[1:0];
                wdata       <= req_wdata;
                mem_address <= eff_addr;
                fault       <= eff_addr >= LIMIT;
                resp_rdata  <= '0;
            end
            if (state == ACCESS) begin
                hold       <= mem_read_data[WORD_W-1:BYTE_W];
                resp_rdata <= (wr || fault) ? '0 : load_data;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table vectors, hand sequences and random traffic against a byte-array model.
module tb_load_store_unit;
`ifdef LSU_ROTATE_EN
    localparam int ROT = 1;
`else
    localparam int ROT = 0;
`endif
    logic        clk = 1'b0;
    logic        mem_reset, req_valid, req_ready, req_write, req_byte;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_address, mem_write_data, mem_read_data;
    logic        resp_valid, resp_fault, mem_write_en, init_mem;
    logic [7:0]  mem [1024];
    logic [7:0]  ref_mem [1024];
    int          n_cmp = 0, n_bad = 0;

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk(clk), .mem_reset(mem_reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_address(mem_address), .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_read_data = 32'hDEADBEEF;
        if (mem_address <= 32'd1020)
            for (int k = 0; k < 4; k++) mem_read_data[8*k +: 8] = mem[int'(mem_address[9:0]) + k];
    end

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            {mem[3], mem[2], mem[1], mem[0]} <= 32'hE3A00014;
            {mem[7], mem[6], mem[5], mem[4]} <= 32'hE3A0D838;
        end else if (mem_write_en && mem_address <= 32'd1020) begin
            for (int k = 0; k < 4; k++) mem[int'(mem_address[9:0]) + k] <= mem_write_data[8*k +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // reference model: memory as a byte array, results assembled lane by lane
    task automatic model(input bit w, input bit b, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic f, output int lat, output int wc);
        logic [31:0] e;
        int i, r;
        e   = (ROT == 1 && !b) ? (a & ~32'd3) : a;
        f   = e >= 32'd1021;
        rd  = '0;
        lat = (w && b && !f) ? 3 : 2;
        wc  = (w && !f) ? 1 : 0;
        r   = ROT == 1 ? int'(a[1:0]) : 0;
        if (!f) begin
            i = int'(e[9:0]);
            if (w && b) ref_mem[i] = d[7:0];
            else if (w) for (int k = 0; k < 4; k++) ref_mem[i + k] = d[8*k +: 8];
            else if (b) rd = {24'd0, ref_mem[i]};
            else for (int k = 0; k < 4; k++) rd[8*k +: 8] = ref_mem[i + ((k + r) % 4)];
        end
    endtask

    // called at a negedge with the DUT idle; returns at the negedge after the response
    task automatic run(input bit w, input bit b, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic f, output int lat, output int wc);
        bit ready_seen = 0;
        rd = '0; f = 0; lat = 99; wc = 0;
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1; req_write = w; req_byte = b; req_addr = a; req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; req_write = 1; req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 8; c++) begin
            if (mem_write_en) wc++;
            if (req_ready) ready_seen = 1;
            if (resp_valid) begin
                lat = c; rd = resp_rdata; f = resp_fault;
                break;
            end
            @(negedge clk);
        end
        chk("ready_low_busy", {31'd0, ready_seen}, 32'd0);
        if (lat == 99) $display("FAIL resp_timeout: got no resp_valid, expected one within 8 cycles");
        @(negedge clk);
        chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    endtask

    typedef struct {
        bit          w, b;
        logic [31:0] a, d, rd;
        bit          f;
        int          lat, wc;
        string       name;
    } vec_t;

    vec_t        tbl[12];
    logic [31:0] rd, mrd;
    logic        f, mf;
    int          lat, wc, mlat, mwc, diffs;

    initial begin
        tbl[0]  = '{0, 0, 32'h004, 32'h0, 32'hE3A0D838, 0, 2, 0, "ld_w_4"};
        tbl[1]  = '{0, 1, 32'h002, 32'h0, 32'h000000A0, 0, 2, 0, "ld_b_2"};
        tbl[2]  = '{0, 0, 32'h001, 32'h0, (ROT == 1 ? 32'h14E3A000 : 32'h38E3A000), 0, 2, 0, "ld_w_1"};
        tbl[3]  = '{1, 0, 32'h100, 32'h11223344, 32'h0, 0, 2, 1, "st_w_100"};
        tbl[4]  = '{1, 1, 32'h101, 32'h000000AB, 32'h0, 0, 3, 1, "st_b_101"};
        tbl[5]  = '{0, 0, 32'h100, 32'h0, 32'h1122AB44, 0, 2, 0, "ld_w_100"};
        tbl[6]  = '{0, 1, 32'h104, 32'h0, 32'h0, 0, 2, 0, "ld_b_104"};
        tbl[7]  = '{0, 0, 32'd1021, 32'h0, 32'h0, (ROT == 0), 2, 0, "ld_w_1021"};
        tbl[8]  = '{1, 0, 32'd1021, 32'hCAFEF00D, 32'h0, (ROT == 0), 2, (ROT == 1 ? 1 : 0), "st_w_1021"};
        tbl[9]  = '{0, 0, 32'd1020, 32'h0, (ROT == 1 ? 32'hCAFEF00D : 32'h0), 0, 2, 0, "ld_w_1020"};
        tbl[10] = '{0, 1, 32'd1021, 32'h0, 32'h0, 1, 2, 0, "ld_b_1021"};
        tbl[11] = '{1, 1, 32'hFFFFFFFF, 32'h77, 32'h0, 1, 2, 0, "st_b_ffffffff"};

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]} = 32'hE3A00014;
        {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]} = 32'hE3A0D838;

        mem_reset = 1; init_mem = 1; req_valid = 0; req_write = 0; req_byte = 0;
        req_addr = 0; req_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_reset = 0; init_mem = 0;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_write_en", {31'd0, mem_write_en}, 32'd0);
        chk("rst_mem_write_data", mem_write_data, 32'd0);

        // directed vectors
        for (int i = 0; i < 12; i++) begin
            run(tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, rd, f, lat, wc);
            model(tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, mrd, mf, mlat, mwc);
            chk({tbl[i].name, "_rdata"}, rd, tbl[i].rd);
            chk({tbl[i].name, "_fault"}, {31'd0, f}, {31'd0, tbl[i].f});
            chk({tbl[i].name, "_latency"}, lat, tbl[i].lat);
            chk({tbl[i].name, "_writes"}, wc, tbl[i].wc);
        end

        // request held valid: accepted only in the cycle after each response
        req_valid = 1; req_write = 0; req_byte = 0; req_addr = 32'h4; req_wdata = 0;
        for (int i = 0; i < 9; i++) begin
            chk("held_ready", {31'd0, req_ready}, {31'd0, i % 3 == 0});
            chk("held_resp", {31'd0, resp_valid}, {31'd0, i % 3 == 2});
            if (i % 3 == 2) chk("held_rdata", resp_rdata, 32'hE3A0D838);
            @(negedge clk);
        end
        req_valid = 0;
        @(negedge clk);

        // reset during the write half of a byte RMW
        run(1, 0, 32'h200, 32'h55667788, rd, f, lat, wc);
        model(1, 0, 32'h200, 32'h55667788, mrd, mf, mlat, mwc);
        req_valid = 1; req_write = 1; req_byte = 1; req_addr = 32'h200; req_wdata = 32'hCD;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        chk("rmw_read_no_we", {31'd0, mem_write_en}, 32'd0);
        @(negedge clk);
        chk("rmw_write_we", {31'd0, mem_write_en}, 32'd1);
        chk("rmw_write_data", mem_write_data, 32'h556677CD);
        mem_reset = 1;
        #1;
        chk("rmw_reset_we_gated", {31'd0, mem_write_en}, 32'd0);
        @(negedge clk);
        mem_reset = 0;
        chk("rmw_reset_ready", {31'd0, req_ready}, 32'd1);
        chk("rmw_reset_resp", {31'd0, resp_valid}, 32'd0);
        chk("rmw_reset_byte", {24'd0, mem[32'h200]}, 32'h88);

        // random traffic against the model
        for (int n = 0; n < 200; n++) begin
            bit          w, b;
            logic [31:0] a, d;
            int          r;
            w = 1'($urandom); b = 1'($urandom); d = $urandom;
            r = $urandom_range(0, 9);
            a = r == 0 ? 32'hFFFFFFFF - $urandom_range(0, 3) :
                r < 3  ? 32'($urandom_range(1016, 1023)) : 32'($urandom_range(0, 1023));
            run(w, b, a, d, rd, f, lat, wc);
            model(w, b, a, d, mrd, mf, mlat, mwc);
            chk("rnd_rdata", rd, mrd);
            chk("rnd_fault", {31'd0, f}, {31'd0, mf});
            chk("rnd_latency", lat, mlat);
            chk("rnd_writes", wc, mwc);
        end

        diffs = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("final_mem_diffs", diffs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
